// File: rtl/timer_irq_src.sv
// Memory-mapped 16-bit machine timer with prescaler, compare match and sticky pending bit.
// Raises INT_CODE on int_flag one cycle after pending&enable; registered 1-cycle bus reads.
module timer_irq_src #(
  parameter int                DW       = 16,
  parameter int                INT_W    = 8,
  parameter logic [INT_W-1:0]  INT_CODE = INT_W'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bus_sel,
  input  logic             bus_we,
  input  logic [1:0]       bus_addr,
  input  logic [DW-1:0]    bus_wdata,
  output logic [DW-1:0]    bus_rdata,
  output logic [INT_W-1:0] int_flag
);

  localparam logic [1:0] A_CTRL  = 2'd0;
  localparam logic [1:0] A_PRESC = 2'd1;
  localparam logic [1:0] A_COUNT = 2'd2;
  localparam logic [1:0] A_CMP   = 2'd3;

  logic          en, ie, ar, pend;
  logic [DW-1:0] presc, count, cmp, pcnt;

  logic          wr, rd;
  logic          wr_ctrl, wr_presc, wr_count, wr_cmp;
  logic          run, tick, match;
  logic [DW-1:0] ctrl_val, rd_mux;

  assign wr       = bus_sel & bus_we;
  assign rd       = bus_sel & ~bus_we;
  assign wr_ctrl  = wr & (bus_addr == A_CTRL);
  assign wr_presc = wr & (bus_addr == A_PRESC);
  assign wr_count = wr & (bus_addr == A_COUNT);
  assign wr_cmp   = wr & (bus_addr == A_CMP);

  // A CTRL write clearing EN stops the prescaler on that very cycle.
  assign run   = en & ~(wr_ctrl & ~bus_wdata[0]);
  assign tick  = run & (pcnt == presc);
  // A software COUNT write overrides both the increment and the compare.
  assign match = tick & ~wr_count & (count == cmp);

  assign ctrl_val = {{(DW-4){1'b0}}, pend, ar, ie, en};

  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      A_CTRL:  rd_mux = ctrl_val;
      A_PRESC: rd_mux = presc;
      A_COUNT: rd_mux = count;
      A_CMP:   rd_mux = cmp;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en        <= 1'b0;
      ie        <= 1'b0;
      ar        <= 1'b0;
      pend      <= 1'b0;
      presc     <= '0;
      count     <= '0;
      cmp       <= '1;
      pcnt      <= '0;
      bus_rdata <= '0;
      int_flag  <= '0;
    end else begin
      if (wr_ctrl) begin
        en <= bus_wdata[0];
        ie <= bus_wdata[1];
        ar <= bus_wdata[2];
      end
      if (wr_presc) presc <= bus_wdata;
      if (wr_cmp)   cmp   <= bus_wdata;

      if (wr_presc || (wr_ctrl && bus_wdata[0] && !en)) begin
        pcnt <= '0;
      end else if (run) begin
        pcnt <= tick ? '0 : pcnt + DW'(1);
      end

      if (wr_count) begin
        count <= bus_wdata;
      end else if (tick) begin
        count <= (match && ar) ? '0 : count + DW'(1);
      end

      // A new match outranks a simultaneous write-1-to-clear.
      if (match) begin
        pend <= 1'b1;
      end else if (wr_ctrl && bus_wdata[3]) begin
        pend <= 1'b0;
      end

      if (rd) bus_rdata <= rd_mux;
      int_flag <= (pend && ie) ? INT_CODE : '0;
    end
  end

endmodule

// File: tb/tb_timer_irq_src.sv
// Randomized and directed bench for timer_irq_src against a register-level behavioural model.
module tb_timer_irq_src;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_sel = 1'b0;
  logic        bus_we = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [15:0] bus_wdata = 16'd0;
  logic [15:0] bus_rdata;
  logic [7:0]  int_flag;

  timer_irq_src dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_sel   (bus_sel),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .int_flag  (int_flag)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: the four architectural registers plus the prescale position.
  bit m_en, m_ie, m_ar, m_pend;
  int m_presc, m_count, m_cmp, m_pcnt, m_rdata, m_int;

  bit pin_rd_chk = 1'b0;
  bit pin_int_chk = 1'b0;
  int pin_rd_val = 0;
  int pin_int_val = 0;

  function automatic int m_reg(int a);
    case (a)
      0: return (int'(m_pend) << 3) | (int'(m_ar) << 2) | (int'(m_ie) << 1) | int'(m_en);
      1: return m_presc;
      2: return m_count;
      default: return m_cmp;
    endcase
  endfunction

  task automatic m_reset();
    m_en = 0; m_ie = 0; m_ar = 0; m_pend = 0;
    m_presc = 0; m_count = 0; m_cmp = 16'hFFFF; m_pcnt = 0;
    m_rdata = 0; m_int = 0;
  endtask

  task automatic m_step();
    int  a, w, nxt_count, nxt_pcnt;
    bit  wr, wc, stop_now, running, tick, hit, nxt_pend;
    a  = int'(bus_addr);
    w  = int'(bus_wdata);
    wr = bus_sel && bus_we;
    wc = wr && a == 0;
    stop_now = wc && (w % 2 == 0);
    running  = m_en && !stop_now;
    tick     = running && (m_pcnt == m_presc);
    hit      = tick && !(wr && a == 2) && (m_count == m_cmp);

    if (wr && a == 1)                    nxt_pcnt = 0;
    else if (wc && (w % 2 == 1) && !m_en) nxt_pcnt = 0;
    else if (running)                    nxt_pcnt = tick ? 0 : m_pcnt + 1;
    else                                 nxt_pcnt = m_pcnt;

    if (wr && a == 2)   nxt_count = w;
    else if (hit && m_ar) nxt_count = 0;
    else if (tick)      nxt_count = (m_count + 1) % 65536;
    else                nxt_count = m_count;

    if (hit)                        nxt_pend = 1;
    else if (wc && ((w / 8) % 2 == 1)) nxt_pend = 0;
    else                            nxt_pend = m_pend;

    if (bus_sel && !bus_we) m_rdata = m_reg(a);
    m_int = (m_pend && m_ie) ? 8'h01 : 0;

    if (wc) begin
      m_en = (w % 2) == 1;
      m_ie = ((w / 2) % 2) == 1;
      m_ar = ((w / 4) % 2) == 1;
    end
    if (wr && a == 1) m_presc = w;
    if (wr && a == 3) m_cmp = w;
    m_pcnt  = nxt_pcnt;
    m_count = nxt_count;
    m_pend  = nxt_pend;
  endtask

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
    #1;
    check("bus_rdata", int'(bus_rdata), m_rdata);
    check("int_flag", int'(int_flag), m_int);
    if (pin_rd_chk)  check("pinned_rdata", int'(bus_rdata), pin_rd_val);
    if (pin_int_chk) check("pinned_int_flag", int'(int_flag), pin_int_val);
  end

  task automatic drive(bit s, bit w, int a, int d);
    @(negedge clk);
    pin_rd_chk  = 1'b0;
    pin_int_chk = 1'b0;
    bus_sel   = s;
    bus_we    = w;
    bus_addr  = 2'(a);
    bus_wdata = 16'(d);
  endtask

  task automatic wr(int a, int d); drive(1'b1, 1'b1, a, d); endtask
  task automatic rd(int a);        drive(1'b1, 1'b0, a, 0); endtask
  task automatic idle();           drive(1'b0, 1'b0, 0, 0); endtask
  task automatic pin_rd(int v);  pin_rd_chk = 1'b1;  pin_rd_val = v;  endtask
  task automatic pin_int(int v); pin_int_chk = 1'b1; pin_int_val = v; endtask

  task automatic reset_pulse();
    idle();
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r, a, d;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(3); pin_rd(16'hFFFF);
    rd(0); pin_rd(0);

    // Auto-reload every 6 ticks with no prescaling.
    wr(1, 0); wr(3, 5); wr(2, 0); wr(0, 7);
    repeat (5) idle();
    idle(); pin_int(0);
    rd(0); pin_rd(16'h000F); pin_int(1);

    // Clear pending, then clear again on the cycle of the next match.
    wr(0, 16'h000F);
    idle(); pin_int(0);
    idle(); idle();
    wr(0, 16'h000F);
    rd(0); pin_rd(16'h000F); pin_int(1);

    // COUNT write on a matching tick wins and suppresses the match.
    wr(0, 8); wr(1, 0); wr(3, 3); wr(2, 3); wr(0, 7);
    wr(2, 16'h0010);
    rd(2); pin_rd(16'h0010);
    rd(0); pin_rd(16'h0007); pin_int(0);

    // IE masked: pending sets silently, then enabling IE raises the flag.
    wr(0, 8); wr(1, 3); wr(3, 2); wr(2, 0); wr(0, 5);
    repeat (20) idle();
    rd(0); pin_rd(16'h000D); pin_int(0);
    wr(0, 7);
    idle(); pin_int(1);

    // Wrap FFFF -> 0000 without a pending flag.
    wr(0, 8); wr(1, 0); wr(3, 2); wr(2, 16'hFFFE); wr(0, 16'h000B);
    idle(); idle();
    rd(2); pin_rd(0);
    rd(0); pin_rd(16'h0003); pin_int(0);

    // Asynchronous reset mid-count.
    wr(0, 16'h0007); wr(3, 1); wr(2, 0);
    repeat (4) idle();
    reset_pulse();
    rd(3); pin_rd(16'hFFFF);
    rd(2); pin_rd(0);
    rd(0); pin_rd(0); pin_int(0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      a = $urandom_range(0, 3);
      if (r < 110) begin
        idle();
      end else if (r < 150) begin
        rd(a);
      end else if (r < 199) begin
        case (a)
          0: d = $urandom_range(0, 15);
          1: d = $urandom_range(0, 3);
          2: d = ($urandom_range(0, 15) == 0) ? $urandom_range(16'hFFF0, 16'hFFFF) : $urandom_range(0, 12);
          default: d = ($urandom_range(0, 15) == 0) ? 16'hFFFF : $urandom_range(0, 12);
        endcase
        wr(a, d);
      end else begin
        reset_pulse();
      end
    end

    idle();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
